// File: rtl/vc_buf_pkg.sv
// vc_buf_pkg: shared helpers and default sizing for the VC input buffer.
//   clog2()          constant ceil(log2(n)), usable in parameter/port widths
//   DEF_*            default configuration (8-bit flits, 8 deep, 4 VCs)
//   PTR_W/CNT_W/VC_W widths derived from the default configuration; modules
//                    with overridden parameters derive their own from clog2()
package vc_buf_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  localparam int DEF_NUM_BITS = 8;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_NUM_VC   = 4;

  localparam int PTR_W = clog2(DEF_DEPTH);
  localparam int CNT_W = clog2(DEF_DEPTH) + 1;
  localparam int VC_W  = clog2(DEF_NUM_VC);

endpackage

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl: pointer/occupancy bookkeeping for one virtual channel.
// Ports:
//   clk, rst_n      clock, synchronous active-high reset
//   push_req        a write targets this VC this cycle
//   pop_req         a read targets this VC this cycle
//   push_ok/pop_ok  accepted write / read (gated by full / empty)
//   empty, full     occupancy flags, combinational from the counter
//   count           occupancy 0..DEPTH
//   wr_ptr, rd_ptr  slot offsets within this VC's partition
module vc_fifo_ctrl
  import vc_buf_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_req,
  input  logic                      pop_req,
  output logic                      push_ok,
  output logic                      pop_ok,
  output logic                      empty,
  output logic                      full,
  output logic [clog2(DEPTH):0]     count,
  output logic [clog2(DEPTH)-1:0]   wr_ptr,
  output logic [clog2(DEPTH)-1:0]   rd_ptr
);

  localparam int PTR_BITS = clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [CNT_BITS-1:0] count_reg;
  logic [PTR_BITS-1:0] wr_ptr_reg;
  logic [PTR_BITS-1:0] rd_ptr_reg;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_BITS'(DEPTH));
  // No bypass: an empty VC rejects the pop even with a same-cycle push,
  // and a full VC rejects the push even with a same-cycle pop.
  assign push_ok = push_req && !full;
  assign pop_ok  = pop_req && !empty;

  assign count  = count_reg;
  assign wr_ptr = wr_ptr_reg;
  assign rd_ptr = rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
      if (push_ok && !pop_ok)
        count_reg <= count_reg + CNT_BITS'(1);
      else if (pop_ok && !push_ok)
        count_reg <= count_reg - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: router input port with NUM_VC virtual-channel FIFOs sharing
// one storage array, one write and one registered read per cycle, and a
// one-cycle credit pulse per accepted pop.
// Ports:
//   clk, rst_n        clock, synchronous active-high reset
//   wr_en/wr_vc/fifo_in   write request, target VC, flit
//   rd_en/rd_vc           read request, source VC
//   fifo_out, rd_valid    registered flit, valid the cycle after a pop
//   empty, full           per-VC flags
//   fifo_counter          packed per-VC occupancy, VC v in slice v
//   err_flags             (only with VC_BUF_ERR_EN) sticky overflow bits
//                         [NUM_VC-1:0], sticky underflow bits [2*NUM_VC-1:NUM_VC]
//   credit_out            one-hot pulse per accepted pop
// Optional feature macro: VC_BUF_ERR_EN
module vc_input_buffer
  import vc_buf_pkg::*;
#(
  parameter int NUM_BITS = 8,
  parameter int DEPTH    = 8,
  parameter int NUM_VC   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [clog2(NUM_VC)-1:0]               wr_vc,
  input  logic [NUM_BITS-1:0]                    fifo_in,
  input  logic                                   rd_en,
  input  logic [clog2(NUM_VC)-1:0]               rd_vc,
  output logic [NUM_BITS-1:0]                    fifo_out,
  output logic                                   rd_valid,
  output logic [NUM_VC-1:0]                      empty,
  output logic [NUM_VC-1:0]                      full,
  output logic [NUM_VC*(clog2(DEPTH)+1)-1:0]     fifo_counter,
`ifdef VC_BUF_ERR_EN
  output logic [2*NUM_VC-1:0]                    err_flags,
`endif
  output logic [NUM_VC-1:0]                      credit_out
);

  localparam int PTR_BITS  = clog2(DEPTH);
  localparam int CNT_BITS  = PTR_BITS + 1;
  localparam int VC_BITS   = clog2(NUM_VC);
  localparam int ADDR_BITS = VC_BITS + PTR_BITS;

  // Address = {vc, ptr}, i.e. vc*DEPTH + ptr since DEPTH is a power of two.
  logic [NUM_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

  logic [NUM_VC-1:0]   push_req, pop_req, push_ok, pop_ok;
  logic [PTR_BITS-1:0] wr_ptr_arr [NUM_VC];
  logic [PTR_BITS-1:0] rd_ptr_arr [NUM_VC];
  logic [ADDR_BITS-1:0] wr_addr, rd_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      assign push_req[gi] = wr_en && (wr_vc == VC_BITS'(gi));
      assign pop_req[gi]  = rd_en && (rd_vc == VC_BITS'(gi));

      vc_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_req (push_req[gi]),
        .pop_req  (pop_req[gi]),
        .push_ok  (push_ok[gi]),
        .pop_ok   (pop_ok[gi]),
        .empty    (empty[gi]),
        .full     (full[gi]),
        .count    (fifo_counter[gi*CNT_BITS +: CNT_BITS]),
        .wr_ptr   (wr_ptr_arr[gi]),
        .rd_ptr   (rd_ptr_arr[gi])
      );
    end
  endgenerate

  assign wr_addr = {wr_vc, wr_ptr_arr[wr_vc]};
  assign rd_addr = {rd_vc, rd_ptr_arr[rd_vc]};

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (|push_ok) mem[wr_addr] <= fifo_in;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      fifo_out   <= '0;
      rd_valid   <= 1'b0;
      credit_out <= '0;
    end else begin
      rd_valid   <= |pop_ok;
      credit_out <= pop_ok;    // rd_vc decode makes this at most one-hot
      if (|pop_ok) fifo_out <= mem[rd_addr];
    end
  end

`ifdef VC_BUF_ERR_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_flags <= '0;
    end else begin
      err_flags <= err_flags | {(pop_req & empty), (push_req & full)};
    end
  end
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
module tb_vc_input_buffer;
  import vc_buf_pkg::*;

  localparam int NB = 8;
  localparam int D  = 8;
  localparam int NV = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en, rd_en;
  logic [VC_W-1:0]   wr_vc, rd_vc;
  logic [NB-1:0]     fifo_in, fifo_out;
  logic              rd_valid;
  logic [NV-1:0]     empty, full, credit_out;
  logic [NV*CNT_W-1:0] fifo_counter;
`ifdef VC_BUF_ERR_EN
  logic [2*NV-1:0]   err_flags;
`endif

  vc_input_buffer #(.NUM_BITS(NB), .DEPTH(D), .NUM_VC(NV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_vc        (wr_vc),
    .fifo_in      (fifo_in),
    .rd_en        (rd_en),
    .rd_vc        (rd_vc),
    .fifo_out     (fifo_out),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .fifo_counter (fifo_counter),
`ifdef VC_BUF_ERR_EN
    .err_flags    (err_flags),
`endif
    .credit_out   (credit_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  // Scoreboard entry: {vc, flit}
  logic [VC_W+NB-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt(input int v);
    return fifo_counter[v*CNT_W +: CNT_W];
  endfunction

  // Monitor: every negedge, a valid output must match the oldest expected pop
  // and credit must pulse only on that VC; otherwise credit must be idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pop: got flit 0x%0h with nothing expected", fifo_out);
        end else begin
          logic [VC_W+NB-1:0] e;
          logic [NV-1:0] oh;
          e = exp_q.pop_front();
          oh = '0;
          oh[e[VC_W+NB-1:NB]] = 1'b1;
          chk("pop_data", {24'd0, fifo_out}, {24'd0, e[NB-1:0]});
          chk("pop_credit", {28'd0, credit_out}, {28'd0, oh});
        end
      end else if (credit_out !== '0) begin
        tests++; fails++;
        $display("FAIL idle_credit: got 0x%0h expected 0x0", credit_out);
      end
    end
  end

  // One cycle of stimulus; exp_rd queues the flit the read should return.
  task automatic op(input bit we, input int wv, input logic [NB-1:0] wd,
                    input bit re, input int rv, input bit exp_rd, input logic [NB-1:0] ed);
    wr_en = we; wr_vc = VC_W'(wv); fifo_in = wd;
    rd_en = re; rd_vc = VC_W'(rv);
    if (exp_rd) exp_q.push_back({VC_W'(rv), ed});
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 0; rd_en = 0; wr_vc = '0; rd_vc = '0; fifo_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_counter", 32'(fifo_counter), 32'd0);
    chk("rst_empty", {28'd0, empty}, 32'hF);
    chk("rst_full", {28'd0, full}, 32'h0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_fifo_out", {24'd0, fifo_out}, 32'd0);
    chk("rst_credit", {28'd0, credit_out}, 32'd0);
    rst_n = 1'b0;
    mon_en = 1'b1;

    // Fill VC2, then overflow attempt
    for (int i = 0; i < 8; i++) op(1, 2, NB'(8'h11 + i), 0, 0, 0, 0);
    chk("vc2_full", {28'd0, full}, 32'h4);
    chk("vc2_count8", {28'd0, cnt(2)}, 32'd8);
    chk("others_empty", {28'd0, empty}, 32'hB);
    op(1, 2, 8'hFF, 0, 0, 0, 0);
    chk("vc2_drop_count", {28'd0, cnt(2)}, 32'd8);

    // Drain VC2 in order
    for (int i = 0; i < 8; i++) op(0, 0, 0, 1, 2, 1, NB'(8'h11 + i));
    chk("vc2_empty", {28'd0, empty}, 32'hF);

    // Write VC0 while reading VC1
    op(1, 1, 8'h3C, 0, 0, 0, 0);
    op(1, 0, 8'hA5, 1, 1, 1, 8'h3C);
    chk("split_cnt0", {28'd0, cnt(0)}, 32'd1);
    chk("split_cnt1", {28'd0, cnt(1)}, 32'd0);
    op(0, 0, 0, 1, 0, 1, 8'hA5);

    // Same-VC on empty VC3: write only, no output
    op(1, 3, 8'h77, 1, 3, 0, 0);
    chk("vc3_empty_rw_cnt", {28'd0, cnt(3)}, 32'd1);
    chk("vc3_empty_rw_valid", {31'd0, rd_valid}, 32'd0);
    for (int i = 0; i < 7; i++) op(1, 3, NB'(8'h78 + i), 0, 0, 0, 0);
    chk("vc3_full", {28'd0, cnt(3)}, 32'd8);
    // Same-VC on full VC3: read only, 0xEE dropped
    op(1, 3, 8'hEE, 1, 3, 1, 8'h77);
    chk("vc3_full_rw_cnt", {28'd0, cnt(3)}, 32'd7);
    for (int i = 0; i < 7; i++) op(0, 0, 0, 1, 3, 1, NB'(8'h78 + i));
    chk("vc3_drained", {28'd0, cnt(3)}, 32'd0);

    // Wrap-around on VC1: overlapped push/pop of 0..19
    op(1, 1, 8'd0, 0, 0, 0, 0);
    for (int i = 1; i < 20; i++) op(1, 1, NB'(i), 1, 1, 1, NB'(i - 1));
    op(0, 0, 0, 1, 1, 1, 8'd19);
    chk("wrap_cnt1", {28'd0, cnt(1)}, 32'd0);

`ifdef VC_BUF_ERR_EN
    chk("err_before_rst", {24'd0, err_flags}, 32'h8C);
`endif

    // Mid-stream reset with VC0 holding flits; concurrent read must lose
    for (int i = 0; i < 5; i++) op(1, 0, NB'(8'h50 + i), 0, 0, 0, 0);
    op(0, 0, 0, 1, 0, 1, 8'h50);
    rst_n = 1'b1;
    op(0, 0, 0, 1, 0, 0, 0);
    chk("midrst_counter", 32'(fifo_counter), 32'd0);
    chk("midrst_fifo_out", {24'd0, fifo_out}, 32'd0);
    chk("midrst_credit", {28'd0, credit_out}, 32'd0);
    chk("midrst_valid", {31'd0, rd_valid}, 32'd0);
    rst_n = 1'b0;
`ifdef VC_BUF_ERR_EN
    chk("err_after_rst", {24'd0, err_flags}, 32'h0);
`endif
    op(0, 0, 0, 1, 0, 0, 0);
    chk("underflow_cnt0", {28'd0, cnt(0)}, 32'd0);
`ifdef VC_BUF_ERR_EN
    chk("err_underflow", {24'd0, err_flags}, 32'h10);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
